uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, next generation of the single-byte serialiser. Adds:
- configurable data width;
- runtime-selectable parity (none/even/odd) and 1 or 2 stop bits;
- an internal write FIFO with valid/ready handshake, so host logic can queue several characters.

It sits between the debug/host-link logic and the FPGA TX pin, driving the line idle-high.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync_fifo.sv | 76 +++++++
 rtl/uart_tx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, transmitter state encoding and parity helpers.
// Used by uart_tx_fifo; kept generic so a future receiver can share it.
package uart_pkg;

   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_EVEN = 2'd1;
   localparam logic [1:0] PARITY_ODD  = 2'd2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   typedef struct packed {
      logic [1:0] parity_mode;
      logic       two_stop;
   } frame_cfg_t;

   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
   endfunction

   // Data is zero-extended to 9 bits by the caller, so unused bits do not disturb the XOR.
   function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Registered synchronous FIFO with push/pop handshake and occupancy count.
// head_valid lags a push into an empty FIFO by one cycle, giving the reader a registered view.
module uart_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DATA_W-1:0]      push_data,
   output logic                   push_ready,
   input  logic                   pop,
   output logic [DATA_W-1:0]      pop_data,
   output logic                   head_valid,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              avail_q, avail_d;
   logic              push_fire;
   logic              pop_fire;

   // A write while full is dropped even if a pop happens in the same cycle.
   assign push_ready = (count_q < CNT_W'(DEPTH));
   assign push_fire  = push && push_ready;
   assign pop_fire   = pop && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_fire) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_fire) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_fire, pop_fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      avail_d = (count_q != '0) && !pop_fire;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         avail_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         avail_q  <= avail_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_fire) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign pop_data   = mem_q[rd_ptr_q];
   assign head_valid = avail_q;
   assign count      = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with write FIFO, runtime parity and 1/2 stop bits.
// Optional line-break generation is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = 40,
   parameter int DATA_BITS      = 8,
   parameter int FIFO_DEPTH     = 4
`ifdef UART_TX_BREAK_EN
   ,
   parameter int BREAK_BITS     = 12
`endif
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [DATA_BITS-1:0]        in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [1:0]                  parity_mode,
   input  logic                        two_stop,
   output logic                        uart_data,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef UART_TX_BREAK_EN
   ,
   input  logic                        send_break
`endif
);

   localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
`ifdef UART_TX_BREAK_EN
   localparam int BIT_MAX = (BREAK_BITS > DATA_BITS) ? BREAK_BITS : DATA_BITS;
`else
   localparam int BIT_MAX = DATA_BITS;
`endif
   localparam int BIT_W = $clog2(BIT_MAX + 1);

   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   frame_cfg_t           cfg_q, cfg_d;
   logic                 line_q, line_d;

   logic                 pop;
   logic [DATA_BITS-1:0] fifo_data;
   logic                 head_valid;
   logic                 push_ready;
   logic                 bit_end;

   uart_sync_fifo #(
      .DATA_W (DATA_BITS),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (in_valid),
      .push_data  (in_data),
      .push_ready (push_ready),
      .pop        (pop),
      .pop_data   (fifo_data),
      .head_valid (head_valid),
      .count      (fifo_count)
   );

   assign bit_end = (clk_cnt_q == CNT_W'(CLOCKS_PER_BIT - 1));

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      cfg_d     = cfg_q;
      line_d    = line_q;
      pop       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
`ifdef UART_TX_BREAK_EN
            if (send_break) begin
               cfg_d.two_stop = 1'b0;
               line_d         = 1'b0;
               state_d        = ST_BREAK;
            end else
`endif
            if (head_valid) begin
               // Frame settings are captured here so later changes only affect the next frame.
               pop      = 1'b1;
               shift_d  = fifo_data;
               parity_d = parity_bit(9'(fifo_data), parity_mode);
               cfg_d    = '{parity_mode: parity_mode, two_stop: two_stop};
               line_d   = 1'b0;
               state_d  = ST_START;
            end
         end

         ST_START: begin
            if (bit_end) begin
               line_d    = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  if (parity_enabled(cfg_q.parity_mode)) begin
                     line_d  = parity_q;
                     state_d = ST_PARITY;
                  end else begin
                     line_d  = 1'b1;
                     state_d = ST_STOP;
                  end
               end else begin
                  line_d    = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end

         ST_PARITY: begin
            if (bit_end) begin
               line_d    = 1'b1;
               bit_cnt_d = '0;
               state_d   = ST_STOP;
            end
         end

         ST_STOP: begin
            if (bit_end) begin
               if (cfg_q.two_stop && (bit_cnt_q == '0)) begin
                  bit_cnt_d = BIT_W'(1);
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

`ifdef UART_TX_BREAK_EN
         ST_BREAK: begin
            if (bit_end) begin
               if (bit_cnt_q == BIT_W'(BREAK_BITS - 1)) begin
                  line_d    = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
`endif

         default: begin
            line_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         line_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         line_q    <= line_d;
      end
   end

   // Frame payload registers carry no reset; they are always reloaded before use.
   always_ff @(posedge clock) begin
      shift_q  <= shift_d;
      parity_q <= parity_d;
      cfg_q    <= cfg_d;
   end

   assign uart_data = line_q;
   assign in_ready  = push_ready && !reset;
   assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven frames, a line monitor fed by a
// scoreboard queue, and directed FIFO-full, mid-frame config change and reset sequences.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DB    = 8;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] parity_mode = 2'd0;
   logic       two_stop = 1'b0;
   logic       uart_data;
   logic       busy;
   logic [2:0] fifo_count;
`ifdef UART_TX_BREAK_EN
   logic       send_break = 1'b0;
`endif

   always #5 clock = ~clock;

   uart_tx_fifo #(
      .CLOCKS_PER_BIT (CPB),
      .DATA_BITS      (DB),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .uart_data   (uart_data),
      .busy        (busy),
      .fifo_count  (fifo_count)
`ifdef UART_TX_BREAK_EN
      ,
      .send_break  (send_break)
`endif
   );

   typedef struct {
      logic [7:0] data;
      logic       has_par;
      logic       par;
      int         nstop;
   } frame_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] pmode;
      logic       two;
      logic       exp_has_par;
      logic       exp_par;
      int         exp_nbits;
   } row_t;

   frame_t sb_q[$];
   int     gap_q[$];
   int     n_checks = 0;
   int     n_fail = 0;
   logic   mon_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Line monitor: every bit must hold its expected level for exactly CPB samples.
   initial begin : monitor
      int     ncyc;
      int     prev_end;
      int     nb;
      logic   bits [0:12];
      logic   ok;
      logic   aborted;
      frame_t f;
      ncyc = 0;
      prev_end = 0;
      forever begin
         @(negedge clock);
         ncyc++;
         if (!reset && uart_data === 1'b0) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: start bit at sample %0d with nothing queued", ncyc);
               while (uart_data !== 1'b1 && !reset) begin
                  @(negedge clock);
                  ncyc++;
               end
            end else begin
               f = sb_q.pop_front();
               mon_busy = 1'b1;
               gap_q.push_back(ncyc - prev_end);
               nb = 0;
               bits[nb] = 1'b0;
               nb++;
               for (int i = 0; i < DB; i++) begin
                  bits[nb] = f.data[i];
                  nb++;
               end
               if (f.has_par) begin
                  bits[nb] = f.par;
                  nb++;
               end
               for (int s = 0; s < f.nstop; s++) begin
                  bits[nb] = 1'b1;
                  nb++;
               end
               aborted = 1'b0;
               for (int b = 0; b < nb && !aborted; b++) begin
                  ok = 1'b1;
                  for (int k = 0; k < CPB && !aborted; k++) begin
                     if (b != 0 || k != 0) begin
                        @(negedge clock);
                        ncyc++;
                     end
                     if (reset) aborted = 1'b1;
                     else if (uart_data !== bits[b]) ok = 1'b0;
                  end
                  if (!aborted) chk($sformatf("line_bit%0d_of_%02h", b, f.data), 32'(ok), 32'd1);
               end
               prev_end = ncyc;
               mon_busy = 1'b0;
            end
         end
      end
   end

   // Drive one write at the current time; the transfer happens on the next posedge.
   task automatic drive(input logic [7:0] d, input logic hp, input logic p, input int ns,
                        output logic accepted);
      frame_t f;
      in_data  = d;
      in_valid = 1'b1;
      accepted = in_ready;
      if (accepted) begin
         f.data = d;
         f.has_par = hp;
         f.par = p;
         f.nstop = ns;
         sb_q.push_back(f);
      end
      @(negedge clock);
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while ((sb_q.size() != 0 || mon_busy || busy !== 1'b0) && t < 3000) begin
         @(negedge clock);
         t++;
      end
      chk({name, "_completion"}, 32'(t < 3000), 32'd1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      row_t tbl [9];
      logic acc;
      int   exp_cnt [5];

      tbl[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 10};
      tbl[1] = '{8'hA5, 2'd1, 1'b0, 1'b1, 1'b0, 11};
      tbl[2] = '{8'hA5, 2'd2, 1'b0, 1'b1, 1'b1, 11};
      tbl[3] = '{8'hA5, 2'd0, 1'b1, 1'b0, 1'b0, 11};
      tbl[4] = '{8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 10};
      tbl[5] = '{8'h01, 2'd1, 1'b1, 1'b1, 1'b1, 12};
      tbl[6] = '{8'hFF, 2'd2, 1'b0, 1'b1, 1'b1, 11};
      tbl[7] = '{8'h80, 2'd1, 1'b0, 1'b1, 1'b1, 11};
      tbl[8] = '{8'h00, 2'd2, 1'b0, 1'b1, 1'b1, 11};
      exp_cnt = '{1, 2, 2, 3, 4};

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_line", 32'(uart_data), 32'd1);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);

      for (int i = 0; i < 9; i++) begin
         parity_mode = tbl[i].pmode;
         two_stop    = tbl[i].two;
         drive(tbl[i].data, tbl[i].exp_has_par, tbl[i].exp_par, tbl[i].two ? 2 : 1, acc);
         in_valid = 1'b0;
         chk($sformatf("row%0d_accepted", i), 32'(acc), 32'd1);
         chk($sformatf("row%0d_line_edge1", i), 32'(uart_data), 32'd1);
         @(negedge clock);
         chk($sformatf("row%0d_line_edge2", i), 32'(uart_data), 32'd1);
         @(negedge clock);
         chk($sformatf("row%0d_start_edge3", i), 32'(uart_data), 32'd0);
         repeat (CPB * tbl[i].exp_nbits - 1) @(negedge clock);
         chk($sformatf("row%0d_busy_last_stop", i), 32'(busy), 32'd1);
         @(negedge clock);
         chk($sformatf("row%0d_busy_fall", i), 32'(busy), 32'd0);
         chk($sformatf("row%0d_idle_line", i), 32'(uart_data), 32'd1);
         wait_done($sformatf("row%0d", i));
      end

      // Five consecutive writes into a depth-4 FIFO, then a write while full.
      parity_mode = 2'd0;
      two_stop    = 1'b0;
      gap_q.delete();
      for (int i = 0; i < 5; i++) begin
         drive(8'(i + 1), 1'b0, 1'b0, 1, acc);
         chk($sformatf("burst%0d_accepted", i), 32'(acc), 32'd1);
         chk($sformatf("burst%0d_count", i), 32'(fifo_count), 32'(exp_cnt[i]));
      end
      chk("burst_full_in_ready", 32'(in_ready), 32'd0);
      drive(8'h06, 1'b0, 1'b0, 1, acc);
      in_valid = 1'b0;
      chk("burst_full_write_refused", 32'(acc), 32'd0);
      chk("burst_full_count_held", 32'(fifo_count), 32'd4);
      wait_done("burst");
      chk("burst_frames", 32'(gap_q.size()), 32'd5);
      for (int i = 1; i < 5 && i < gap_q.size(); i++) begin
         chk($sformatf("burst_gap%0d", i), 32'(gap_q[i]), 32'd2);
      end
      chk("burst_end_count", 32'(fifo_count), 32'd0);

      // Config change while a frame is on the line only affects the next frame.
      drive(8'h5A, 1'b0, 1'b0, 1, acc);
      in_valid = 1'b0;
      repeat (20) @(negedge clock);
      parity_mode = 2'd2;
      two_stop    = 1'b1;
      drive(8'h0F, 1'b1, 1'b1, 2, acc);
      in_valid = 1'b0;
      chk("midcfg_second_accepted", 32'(acc), 32'd1);
      wait_done("midcfg");

      // Reset during data bit 3 truncates the frame and empties the FIFO.
      parity_mode = 2'd0;
      two_stop    = 1'b0;
      drive(8'hC3, 1'b0, 1'b0, 1, acc);
      in_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      drive(8'h11, 1'b0, 1'b0, 1, acc);
      in_valid = 1'b0;
      repeat (15) @(negedge clock);
      chk("rstmid_line_bit3", 32'(uart_data), 32'd0);
      chk("rstmid_count_before", 32'(fifo_count), 32'd1);
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      chk("rstmid_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clock);
      @(negedge clock);
      chk("rstmid_line_high", 32'(uart_data), 32'd1);
      chk("rstmid_count_cleared", 32'(fifo_count), 32'd0);
      chk("rstmid_busy_low", 32'(busy), 32'd0);
      sb_q.delete();
      reset = 1'b0;
      #1;
      chk("rstmid_in_ready_high", 32'(in_ready), 32'd1);
      @(negedge clock);
      drive(8'h3A, 1'b0, 1'b0, 1, acc);
      in_valid = 1'b0;
      chk("rstmid_new_accepted", 32'(acc), 32'd1);
      wait_done("rstmid_new");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
